// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit type encoding, direction indices and
// the small helpers used by the output-port VC arbiter.
package noc_pkg;

  localparam int NOC_FLIT_W   = 10;
  localparam int NOC_NUM_VC   = 5;
  localparam int NOC_VC_IDX_W = 3;

  // Direction / VC indices
  localparam int DIR_N = 0;
  localparam int DIR_S = 1;
  localparam int DIR_E = 2;
  localparam int DIR_W = 3;
  localparam int DIR_L = 4;

  // Flit type lives in the top two bits of every flit
  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Round-robin successor of a VC index, wrapping after the last VC
  function automatic logic [NOC_VC_IDX_W-1:0] vc_next(input logic [NOC_VC_IDX_W-1:0] idx);
    if (idx >= NOC_VC_IDX_W'(NOC_NUM_VC - 1)) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority encoder: the first requester found when
// scanning upward from rr_ptr (modulo N) wins.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int N     = NOC_NUM_VC,
  parameter int IDX_W = NOC_VC_IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic found;

  // Scan from rr_ptr upward and take the first active request
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    any     = |req;
    for (int k = 0; k < N; k++) begin
      int v;
      v = (int'(rr_ptr) + k) % N;
      if (!found && req[v]) begin
        found   = 1'b1;
        gnt[v]  = 1'b1;
        gnt_idx = IDX_W'(v);
      end
    end
  end

endmodule

// File: rtl/output_vc_arbiter.sv
// Packet-aware round-robin scheduler for the five VC buffers of one output
// port. Pops one flit per cycle into a registered output stage and keeps a
// VC locked from head to tail so packets never interleave on the link.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | no packet in flight; arbitrate among non-empty VCs
//   ST_LOCKED | packet in flight on grant_q; serve only that VC until tail
module output_vc_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_VC   = 5,
  parameter int FLIT_W   = 10,
  parameter int VC_IDX_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_VC-1:0]        vc_empty,
  input  logic [NUM_VC*FLIT_W-1:0] vc_data,
  output logic [NUM_VC-1:0]        vc_read_en,
  output logic [FLIT_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [VC_IDX_W-1:0]      grant_vc,
  output logic                     busy,
  output logic                     err
);

  arb_state_e            state_q, state_d;
  logic [VC_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [VC_IDX_W-1:0]   grant_q, grant_d;
  logic                  err_q, err_d;
  logic                  out_valid_q, out_valid_d;
  logic [FLIT_W-1:0]     out_data_q, out_data_d;

  logic [NUM_VC-1:0]     pop;
  logic                  load;
  logic                  stage_free;
  logic [FLIT_W-1:0]     cand;
  logic [NUM_VC-1:0]     arb_gnt;
  logic [VC_IDX_W-1:0]   arb_idx;
  logic                  arb_any;

  rr_arbiter #(
    .N     (NUM_VC),
    .IDX_W (VC_IDX_W)
  ) u_rr_arbiter (
    .req     (~vc_empty),
    .rr_ptr  (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign stage_free = !out_valid_q || out_ready;

  // Next-state, pop and output-load decisions; nothing moves while stalled
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pop         = '0;
    load        = 1'b0;
    cand        = '0;

    if (stage_free) begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            cand = vc_data[int'(arb_idx)*FLIT_W +: FLIT_W];
            pop  = arb_gnt;
            unique case (cand[FLIT_W-1 -: 2])
              FT_HEAD: begin
                load    = 1'b1;
                state_d = ST_LOCKED;
                grant_d = arb_idx;
              end
              FT_SINGLE: begin
                load     = 1'b1;
                rr_ptr_d = vc_next(arb_idx);
              end
              default: begin
                // Orphan BODY/TAIL: discard it so the VC cannot jam the port
                err_d    = 1'b1;
                rr_ptr_d = vc_next(arb_idx);
              end
            endcase
          end
        end
        ST_LOCKED: begin
          if (!vc_empty[grant_q]) begin
            cand = vc_data[int'(grant_q)*FLIT_W +: FLIT_W];
            unique case (cand[FLIT_W-1 -: 2])
              FT_BODY: begin
                pop  = NUM_VC'(1) << grant_q;
                load = 1'b1;
              end
              FT_TAIL: begin
                pop      = NUM_VC'(1) << grant_q;
                load     = 1'b1;
                state_d  = ST_IDLE;
                rr_ptr_d = vc_next(grant_q);
              end
              default: begin
                // New packet start inside a packet: abandon the lock, keep the flit
                err_d    = 1'b1;
                state_d  = ST_IDLE;
                rr_ptr_d = vc_next(grant_q);
              end
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase

      out_valid_d = load;
      if (load) out_data_d = cand;
    end
  end

  // All arbiter state and the output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign vc_read_en = reset ? '0 : pop;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign grant_vc   = grant_q;
  assign busy       = (state_q == ST_LOCKED);
  assign err        = err_q;

endmodule

// File: tb/tb_output_vc_arbiter.sv
// Bench for output_vc_arbiter: the VC buffers are modelled as queues, and a
// packet-level reference model predicts pops and outputs every cycle.
module tb_output_vc_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  vc_empty;
  logic [49:0] vc_data;
  logic [4:0]  vc_read_en;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  grant_vc;
  logic        busy;
  logic        err;

  output_vc_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .vc_empty   (vc_empty),
    .vc_data    (vc_data),
    .vc_read_en (vc_read_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .grant_vc   (grant_vc),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [9:0] q [5][$];
  logic [9:0] out_log [$];
  bit         in_pkt [5];

  // reference model state
  bit         m_locked;
  int         m_grant;
  int         m_rr;
  bit         m_err;
  bit         m_ov;
  logic [9:0] m_od;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_grant = 0; m_rr = 0; m_err = 0; m_ov = 0; m_od = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < 5; i++) begin
      vc_empty[i] = (q[i].size() == 0);
      vc_data[10*i +: 10] = (q[i].size() != 0) ? q[i][0] : 10'($urandom);
    end
  endtask

  // One clock cycle; entered and left at a falling edge
  task automatic cycle();
    int pop_i;
    int w;
    int v;
    bit ld;
    bit free;
    logic [9:0] f;
    logic [4:0] exp_rd;
    drive();
    pop_i = -1; ld = 0; f = '0;
    free = !m_ov || out_ready;
    if (free) begin
      if (!m_locked) begin
        w = -1;
        for (int k = 0; k < 5; k++) begin
          v = (m_rr + k) % 5;
          if (w < 0 && q[v].size() > 0) w = v;
        end
        if (w >= 0) begin
          f = q[w][0];
          pop_i = w;
          case (f[9:8])
            2'b01: begin ld = 1; m_locked = 1; m_grant = w; end
            2'b11: begin ld = 1; m_rr = (w + 1) % 5; end
            default: begin m_err = 1; m_rr = (w + 1) % 5; end
          endcase
        end
      end else if (q[m_grant].size() > 0) begin
        f = q[m_grant][0];
        case (f[9:8])
          2'b00: begin pop_i = m_grant; ld = 1; end
          2'b10: begin pop_i = m_grant; ld = 1; m_locked = 0; m_rr = (m_grant + 1) % 5; end
          default: begin m_err = 1; m_locked = 0; m_rr = (m_grant + 1) % 5; end
        endcase
      end
      m_ov = ld;
      if (ld) m_od = f;
    end
    exp_rd = (pop_i >= 0) ? (5'd1 << pop_i) : 5'd0;
    #1;
    check("rd_en", 32'(vc_read_en), 32'(exp_rd));
    if (out_valid && out_ready) out_log.push_back(out_data);
    @(posedge clk);
    if (pop_i >= 0) void'(q[pop_i].pop_front());
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data", 32'(out_data), 32'(m_od));
    check("busy", 32'(busy), 32'(m_locked));
    if (m_locked) check("grant_vc", 32'(grant_vc), 32'(m_grant));
    check("err", 32'(err), 32'(m_err));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset asserted in the middle of a low phase; entered and left at a falling edge
  task automatic do_reset();
    drive();
    #3 reset = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_vc), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rd_en", 32'(vc_read_en), 0);
    @(posedge clk);
    #1 check("rst_rd_en_edge", 32'(vc_read_en), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic clear_all();
    for (int i = 0; i < 5; i++) begin
      q[i].delete();
      in_pkt[i] = 0;
    end
    out_log.delete();
  endtask

  task automatic check_log(input string tag, input logic [9:0] exp [$]);
    check({tag, "_len"}, 32'(out_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < out_log.size(); i++)
      check(tag, 32'(out_log[i]), 32'(exp[i]));
  endtask

  task automatic rand_push();
    int v;
    int r;
    logic [1:0] t;
    if ($urandom_range(0, 99) < 45) begin
      v = $urandom_range(0, 4);
      r = $urandom_range(0, 99);
      if (q[v].size() < 8) begin
        if (in_pkt[v]) begin
          if (r < 30) begin t = 2'b10; in_pkt[v] = 0; end
          else t = 2'b00;
        end else if (r < 55) begin t = 2'b01; in_pkt[v] = 1; end
        else if (r < 93) t = 2'b11;
        else t = (r < 96) ? 2'b00 : 2'b10;
        q[v].push_back({t, 8'($urandom)});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    clear_all();
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // packet on VC1 completes before the single on VC3
    clear_all();
    q[1].push_back(10'h1AA); q[1].push_back(10'h0BB); q[1].push_back(10'h2CC);
    q[3].push_back(10'h3DD);
    out_ready = 1'b1;
    run(8);
    check_log("pkt_seq", '{10'h1AA, 10'h0BB, 10'h2CC, 10'h3DD});

    // one single per VC: round-robin order N,S,E,W,L, pointer wraps back to N
    do_reset();
    clear_all();
    for (int i = 0; i < 5; i++) q[i].push_back(10'h301 + 10'(i));
    run(8);
    check_log("rr_seq", '{10'h301, 10'h302, 10'h303, 10'h304, 10'h305});
    out_log.delete();
    q[4].push_back(10'h3A4);
    q[0].push_back(10'h3A0);
    run(4);
    check_log("rr_wrap", '{10'h3A0, 10'h3A4});

    // stall with VC2 locked
    do_reset();
    clear_all();
    q[2].push_back(10'h155); q[2].push_back(10'h066); q[2].push_back(10'h277);
    run(1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_data", 32'(out_data), 32'h155);
    end
    out_ready = 1'b1;
    cycle();
    check("release_body", 32'(out_data), 32'h066);
    run(3);

    // orphan BODY while idle is dropped and err sticks
    do_reset();
    clear_all();
    q[0].push_back(10'h011);
    run(2);
    check("drop_err", 32'(err), 1);
    check("drop_valid", 32'(out_valid), 0);
    run(3);
    check("err_sticky", 32'(err), 1);

    // locked VC4 runs dry before its tail
    do_reset();
    clear_all();
    q[4].push_back(10'h1E0); q[4].push_back(10'h0E1);
    run(4);
    check("dry_busy", 32'(busy), 1);
    check("dry_valid", 32'(out_valid), 0);
    q[4].push_back(10'h2FF);
    cycle();
    check("tail_data", 32'(out_data), 32'h2FF);
    check("tail_valid", 32'(out_valid), 1);
    check("tail_busy", 32'(busy), 0);

    // reset mid-packet with flits queued
    clear_all();
    q[1].push_back(10'h1C1); q[1].push_back(10'h0C2);
    q[2].push_back(10'h3C3);
    run(1);
    do_reset();

    // randomized traffic with random backpressure and occasional resets
    for (int c = 0; c < 3000; c++) begin
      rand_push();
      out_ready = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
